// File: rtl/bus_assign_pkg.sv
// Shared limits, types and the masking helper for the masked bus-assign pipeline.
package bus_assign_pkg;

    localparam int MAX_WIDTH  = 64;
    localparam int MAX_STAGES = 4;

    typedef logic [2:0] occupancy_t;

    function automatic logic [MAX_WIDTH-1:0] apply_mask(
        input logic [MAX_WIDTH-1:0] data,
        input logic [MAX_WIDTH-1:0] mask,
        input logic [MAX_WIDTH-1:0] undriven
    );
        return (data & mask) | (undriven & ~mask);
    endfunction

endpackage

// File: rtl/bus_assign_stage.sv
// One valid/data slot of the masked bus pipeline with its advance logic.
module bus_assign_stage
    import bus_assign_pkg::*;
#(
    parameter int               WIDTH     = 6,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_next_ready,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Slot accepts when empty or when its current beat moves on this cycle.
    assign o_ready = !r_valid || i_next_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/bus_assign_masked_pipe.sv
// Masked source-to-sink bus copy through a STAGES-deep valid/ready pipeline.
module bus_assign_masked_pipe
    import bus_assign_pkg::*;
#(
    parameter int               WIDTH        = 6,
    parameter int               STAGES       = 2,
    parameter logic [WIDTH-1:0] CONN_MASK    = 6'b110111,
    parameter logic [WIDTH-1:0] UNDRIVEN_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_bus,
    output logic             snk_valid,
    input  logic             snk_ready,
    output logic [WIDTH-1:0] snk_bus,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] cfg_mask,
    output logic [WIDTH-1:0] active_mask,
    output occupancy_t       occupancy
);

    generate
        if (STAGES < 1 || STAGES > MAX_STAGES || WIDTH < 1 || WIDTH > MAX_WIDTH)
        begin : g_bad_params
            $error("bus_assign_masked_pipe: WIDTH or STAGES out of range");
        end
    endgenerate

    logic [WIDTH-1:0] r_mask;
    occupancy_t       r_occ;
    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_ready;
    logic [WIDTH-1:0] w_data [0:STAGES];
    logic             w_accept;
    logic             w_deliver;

    // Data is bound to the mask in force on the acceptance cycle.
    assign w_valid[0] = src_valid;
    assign w_data[0]  = WIDTH'(apply_mask(MAX_WIDTH'(src_bus),
                                          MAX_WIDTH'(r_mask),
                                          MAX_WIDTH'(UNDRIVEN_VAL)));
    assign w_ready[STAGES] = snk_ready;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            bus_assign_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (UNDRIVEN_VAL)
            ) u_stage (
                .clk          (clk),
                .rst          (rst),
                .i_valid      (w_valid[k]),
                .i_data       (w_data[k]),
                .i_next_ready (w_ready[k+1]),
                .o_ready      (w_ready[k]),
                .o_valid      (w_valid[k+1]),
                .o_data       (w_data[k+1])
            );
        end
    endgenerate

    assign src_ready   = w_ready[0];
    assign snk_valid   = w_valid[STAGES];
    assign snk_bus     = w_data[STAGES];
    assign active_mask = r_mask;
    assign occupancy   = r_occ;

    assign w_accept  = src_valid && w_ready[0];
    assign w_deliver = w_valid[STAGES] && snk_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= CONN_MASK;
        end else if (cfg_wr) begin
            r_mask <= cfg_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_accept && !w_deliver) begin
            r_occ <= r_occ + 3'd1;
        end else if (!w_accept && w_deliver) begin
            r_occ <= r_occ - 3'd1;
        end
    end

endmodule
